// File: rtl/fetch_predict_unit.sv
// ---------------------------------------------------------------------------
// fetch_predict_unit
//
// Instruction-fetch front end for a 5-stage RV32I pipeline. Owns the PC,
// addresses the (combinational) instruction ROM, holds the IF/ID pipeline
// register and predicts the next PC with a direct-mapped branch target
// buffer (BTB) whose entries carry a 2-bit saturating direction counter.
//
// Ports
//   clk                  rising-edge clock
//   rst                  synchronous, active-high reset (beats every input)
//   stall_i              hold PC and IF/ID this cycle
//   redirect_i           downstream resolved a mispredict/jump: flush + refetch
//   redirect_pc_i        correct next PC (low two bits ignored)
//   upd_valid_i          a resolved control-flow instruction updates the BTB
//   upd_pc_i             PC of that instruction
//   upd_taken_i          its actual outcome
//   upd_target_i         its actual taken target
//   imem_addr_o          ROM word address (pc[IMEM_AW+1:2], wraps naturally)
//   imem_rdata_i         ROM data for imem_addr_o, same cycle
//   pc_o                 current IF-stage PC
//   if_id_valid_o        IF/ID holds a real instruction
//   if_id_pc_o           PC of the IF/ID instruction
//   if_id_instr_o        IF/ID instruction word
//   if_id_pred_taken_o   prediction made for that instruction
//   if_id_pred_target_o  predicted target (meaningful when pred_taken = 1)
//
// Flow control: if_id_valid_o marks a real instruction in IF/ID. While
// stall_i is high (and no redirect) the consumer is not ready, so the PC and
// every IF/ID field hold their value; the same instruction is offered again
// on the next cycle. redirect_i always wins over stall_i and turns IF/ID into
// a bubble.
// ---------------------------------------------------------------------------
module fetch_predict_unit #(
    parameter int              XLEN        = 32,
    parameter int              IMEM_AW     = 6,
    parameter int              BTB_ENTRIES = 16,
    parameter int              TAG_W       = 8,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    input  logic               upd_valid_i,
    input  logic [XLEN-1:0]    upd_pc_i,
    input  logic               upd_taken_i,
    input  logic [XLEN-1:0]    upd_target_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_rdata_i,
    output logic [XLEN-1:0]    pc_o,
    output logic               if_id_valid_o,
    output logic [XLEN-1:0]    if_id_pc_o,
    output logic [31:0]        if_id_instr_o,
    output logic               if_id_pred_taken_o,
    output logic [XLEN-1:0]    if_id_pred_target_o
);

    localparam int          IDX     = $clog2(BTB_ENTRIES);
    localparam int          TAG_LO  = IDX + 2;
    localparam int          TAG_HI  = IDX + 2 + TAG_W - 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [1:0]  CTR_RST = 2'b01;
    localparam logic [1:0]  CTR_NEW = 2'b10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;

    logic             btb_valid [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag   [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_tgt   [BTB_ENTRIES];
    logic [1:0]       btb_ctr   [BTB_ENTRIES];

    logic             if_id_valid_q;
    logic [XLEN-1:0]  if_id_pc_q;
    logic [31:0]      if_id_instr_q;
    logic             if_id_pred_taken_q;
    logic [XLEN-1:0]  if_id_pred_target_q;

    // ------------------------------------------------------------------
    // Lookup on the current PC (reads registered BTB contents, so a same-
    // cycle update to the same entry is only seen on the following cycle)
    // ------------------------------------------------------------------
    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;

    assign lk_idx = pc_q[IDX+1:2];
    assign lk_tag = pc_q[TAG_HI:TAG_LO];

    always_comb begin
        lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
        pred_taken  = lk_hit && btb_ctr[lk_idx][1];
        pred_target = btb_tgt[lk_idx];
    end

    // ------------------------------------------------------------------
    // Next PC: redirect > stall > predicted taken > sequential
    // ------------------------------------------------------------------
    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (redirect_i) begin
            pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register: flush beats stall, stall holds every field
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_valid_q       <= 1'b0;
            if_id_pc_q          <= '0;
            if_id_instr_q       <= NOP;
            if_id_pred_taken_q  <= 1'b0;
            if_id_pred_target_q <= '0;
        end else if (redirect_i) begin
            // The PC field is left as is; it is meaningless in a bubble.
            if_id_valid_q       <= 1'b0;
            if_id_instr_q       <= NOP;
            if_id_pred_taken_q  <= 1'b0;
            if_id_pred_target_q <= '0;
        end else if (!stall_i) begin
            if_id_valid_q       <= 1'b1;
            if_id_pc_q          <= pc_q;
            if_id_instr_q       <= imem_rdata_i;
            if_id_pred_taken_q  <= pred_taken;
            if_id_pred_target_q <= pred_target;
        end
    end

    // ------------------------------------------------------------------
    // BTB update from the resolve stage. Applied independently of stall
    // and redirect; only reset overrides it.
    // ------------------------------------------------------------------
    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       up_ctr_next;

    assign up_idx = upd_pc_i[IDX+1:2];
    assign up_tag = upd_pc_i[TAG_HI:TAG_LO];

    always_comb begin
        up_hit      = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
        up_ctr_next = btb_ctr[up_idx];
        if (upd_taken_i) begin
            if (btb_ctr[up_idx] != 2'b11) begin
                up_ctr_next = btb_ctr[up_idx] + 2'b01;
            end
        end else begin
            if (btb_ctr[up_idx] != 2'b00) begin
                up_ctr_next = btb_ctr[up_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_tag[i]   <= '0;
                btb_tgt[i]   <= '0;
                btb_ctr[i]   <= CTR_RST;
            end
        end else if (upd_valid_i) begin
            if (up_hit) begin
                btb_ctr[up_idx] <= up_ctr_next;
                if (upd_taken_i) begin
                    btb_tgt[up_idx] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                // Miss on a taken branch: allocate, replacing any alias.
                btb_valid[up_idx] <= 1'b1;
                btb_tag[up_idx]   <= up_tag;
                btb_tgt[up_idx]   <= upd_target_i;
                btb_ctr[up_idx]   <= CTR_NEW;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr_o         = pc_q[IMEM_AW+1:2];
    assign pc_o                = pc_q;
    assign if_id_valid_o       = if_id_valid_q;
    assign if_id_pc_o          = if_id_pc_q;
    assign if_id_instr_o       = if_id_instr_q;
    assign if_id_pred_taken_o  = if_id_pred_taken_q;
    assign if_id_pred_target_o = if_id_pred_target_q;

    // Address bits that never take part in indexing or tagging.
    logic unused_bits;
    generate
        if (TAG_HI < XLEN - 1) begin : g_unused_hi
            assign unused_bits = ^{redirect_pc_i[1:0], upd_pc_i[1:0],
                                   upd_pc_i[XLEN-1:TAG_HI+1]};
        end else begin : g_unused_lo
            assign unused_bits = ^{redirect_pc_i[1:0], upd_pc_i[1:0]};
        end
    endgenerate

endmodule

// File: tb/tb_fetch_predict_unit.sv
module tb_fetch_predict_unit;

    localparam int N = 16;      // BTB entries
    localparam int ROM_WORDS = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_pred_taken;
    logic [31:0] if_id_pred_target;

    logic [31:0] rom [ROM_WORDS];
    assign imem_rdata = rom[imem_addr];

    fetch_predict_unit #(
        .XLEN(32), .IMEM_AW(6), .BTB_ENTRIES(16), .TAG_W(8), .RESET_PC(32'h0)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_i             (stall),
        .redirect_i          (redirect),
        .redirect_pc_i       (redirect_pc),
        .upd_valid_i         (upd_valid),
        .upd_pc_i            (upd_pc),
        .upd_taken_i         (upd_taken),
        .upd_target_i        (upd_target),
        .imem_addr_o         (imem_addr),
        .imem_rdata_i        (imem_rdata),
        .pc_o                (pc),
        .if_id_valid_o       (if_id_valid),
        .if_id_pc_o          (if_id_pc),
        .if_id_instr_o       (if_id_instr),
        .if_id_pred_taken_o  (if_id_pred_taken),
        .if_id_pred_target_o (if_id_pred_target)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Registered state of the unit as the rules describe it, advanced once
    // per rising edge from the same inputs the DUT sees.
    bit          m_ready = 0;
    logic [31:0] m_pc;
    bit          m_if_valid;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_instr;
    bit          m_if_pt;
    logic [31:0] m_if_tgt;
    bit          m_valid [N];
    int          m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];

    always @(posedge clk) begin : model
        int idx, tag, uidx, utag;
        bit pt;
        logic [31:0] ptgt, fetched, npc;
        if (rst) begin
            m_ready    = 1;
            m_pc       = 32'h0;
            m_if_valid = 0;
            m_if_pc    = 32'h0;
            m_if_instr = 32'h13;
            m_if_pt    = 0;
            m_if_tgt   = 32'h0;
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0;
                m_tag[i]   = 0;
                m_tgt[i]   = 32'h0;
                m_ctr[i]   = 1;
            end
        end else if (m_ready) begin
            idx     = int'((m_pc / 4) % N);
            tag     = int'((m_pc / (4 * N)) % 256);
            pt      = m_valid[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
            ptgt    = m_tgt[idx];
            fetched = rom[int'((m_pc / 4) % ROM_WORDS)];
            if (redirect) begin
                npc        = redirect_pc & 32'hFFFF_FFFC;
                m_if_valid = 0;
                m_if_instr = 32'h13;
                m_if_pt    = 0;
            end else if (stall) begin
                npc = m_pc;
            end else begin
                npc        = pt ? ptgt : m_pc + 32'd4;
                m_if_valid = 1;
                m_if_pc    = m_pc;
                m_if_instr = fetched;
                m_if_pt    = pt;
                m_if_tgt   = ptgt;
            end
            m_pc = npc;
            if (upd_valid) begin
                uidx = int'((upd_pc / 4) % N);
                utag = int'((upd_pc / (4 * N)) % 256);
                if (m_valid[uidx] && m_tag[uidx] == utag) begin
                    if (upd_taken) begin
                        m_ctr[uidx] = (m_ctr[uidx] >= 3) ? 3 : m_ctr[uidx] + 1;
                        m_tgt[uidx] = upd_target;
                    end else begin
                        m_ctr[uidx] = (m_ctr[uidx] <= 0) ? 0 : m_ctr[uidx] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[uidx] = 1;
                    m_tag[uidx]   = utag;
                    m_tgt[uidx]   = upd_target;
                    m_ctr[uidx]   = 2;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin : compare
        if (m_ready) begin
            chk("pc_o", pc, m_pc);
            chk("imem_addr_o", 32'(imem_addr), (m_pc / 4) % ROM_WORDS);
            chk("if_id_valid", 32'(if_id_valid), 32'(m_if_valid));
            chk("if_id_instr", if_id_instr, m_if_instr);
            chk("if_id_pred_taken", 32'(if_id_pred_taken), 32'(m_if_pt));
            if (m_if_valid) chk("if_id_pc", if_id_pc, m_if_pc);
            if (m_if_pt)    chk("if_id_pred_target", if_id_pred_target, m_if_tgt);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst         = 0;
        stall       = 0;
        redirect    = 0;
        redirect_pc = 32'h0;
        upd_valid   = 0;
        upd_pc      = 32'h0;
        upd_taken   = 0;
        upd_target  = 32'h0;
    endtask

    task automatic btb_update(input logic [31:0] p, input bit taken, input logic [31:0] tgt);
        upd_valid  = 1;
        upd_pc     = p;
        upd_taken  = taken;
        upd_target = tgt;
        step();
        upd_valid  = 0;
    endtask

    // Redirect to addr, let it reach IF/ID, check its prediction and the PC after it.
    task automatic fetch_at(input logic [31:0] addr, input bit exp_pt, input logic [31:0] exp_next);
        redirect    = 1;
        redirect_pc = addr;
        step();
        redirect    = 0;
        chk("fetch pc_o", pc, addr);
        step();
        chk("fetch if_id_pc", if_id_pc, addr);
        chk("fetch pred_taken", 32'(if_id_pred_taken), 32'(exp_pt));
        chk("fetch next pc_o", pc, exp_next);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
        idle();
        rst = 1;
        step();
        step();
        chk("reset pc_o", pc, 32'h0);
        chk("reset if_id_valid", 32'(if_id_valid), 32'h0);
        chk("reset if_id_instr", if_id_instr, 32'h13);
        chk("reset if_id_pc", if_id_pc, 32'h0);
        chk("reset pred_taken", 32'(if_id_pred_taken), 32'h0);
        chk("reset pred_target", if_id_pred_target, 32'h0);

        // Free run: first valid instruction one cycle after reset drops.
        rst = 0;
        step();
        chk("run pc 4", pc, 32'h4);
        chk("run valid", 32'(if_id_valid), 32'h1);
        chk("run if_id_pc 0", if_id_pc, 32'h0);
        chk("run instr 0", if_id_instr, rom[0]);
        step();
        chk("run pc 8", pc, 32'h8);
        chk("run if_id_pc 4", if_id_pc, 32'h4);
        step();
        chk("run pc 12", pc, 32'hC);

        // Allocation on a taken miss; the fetch of 0x10 follows it.
        btb_update(32'h10, 1, 32'h40);
        chk("alloc pc 0x10", pc, 32'h10);
        step();
        chk("pred pc 0x40", pc, 32'h40);
        chk("pred taken", 32'(if_id_pred_taken), 32'h1);
        chk("pred target", if_id_pred_target, 32'h40);

        // 10 -> 01 -> 00: not taken.
        btb_update(32'h10, 0, 32'h0);
        btb_update(32'h10, 0, 32'h0);
        fetch_at(32'h10, 0, 32'h14);
        // Saturate low, then climb to 11 (saturating high).
        btb_update(32'h10, 0, 32'h0);
        for (int i = 0; i < 4; i++) btb_update(32'h10, 1, 32'h40);
        fetch_at(32'h10, 1, 32'h40);
        // 11 -> 10 -> 01: not taken again.
        btb_update(32'h10, 0, 32'h0);
        btb_update(32'h10, 0, 32'h0);
        fetch_at(32'h10, 0, 32'h14);

        // Stall at pc 0x08 for three cycles.
        redirect    = 1;
        redirect_pc = 32'h4;
        step();
        redirect    = 0;
        step();
        chk("pre-stall pc", pc, 32'h8);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall pc", pc, 32'h8);
            chk("stall valid", 32'(if_id_valid), 32'h1);
            chk("stall if_id_pc", if_id_pc, 32'h4);
            chk("stall instr", if_id_instr, rom[1]);
        end
        stall = 0;
        step();
        chk("release pc", pc, 32'hC);
        chk("release if_id_pc", if_id_pc, 32'h8);
        chk("release instr", if_id_instr, rom[2]);

        // Redirect beats stall; low bits dropped.
        stall       = 1;
        redirect    = 1;
        redirect_pc = 32'h23;
        step();
        idle();
        chk("flush pc", pc, 32'h20);
        chk("flush valid", 32'(if_id_valid), 32'h0);
        chk("flush instr", if_id_instr, 32'h13);
        chk("flush pred_taken", 32'(if_id_pred_taken), 32'h0);

        // Reset wins over a concurrent redirect and update.
        btb_update(32'h10, 1, 32'h40);
        rst         = 1;
        redirect    = 1;
        redirect_pc = 32'h80;
        upd_valid   = 1;
        upd_pc      = 32'h10;
        upd_taken   = 1;
        upd_target  = 32'h40;
        step();
        idle();
        chk("mid-reset pc", pc, 32'h0);
        chk("mid-reset valid", 32'(if_id_valid), 32'h0);
        fetch_at(32'h10, 0, 32'h14);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            stall       = ($urandom_range(0, 99) < 20);
            redirect    = ($urandom_range(0, 99) < 8);
            redirect_pc = $urandom_range(0, 255);
            upd_valid   = ($urandom_range(0, 99) < 35);
            upd_pc      = $urandom_range(0, 255) & 32'hFC;
            upd_taken   = ($urandom_range(0, 99) < 60);
            upd_target  = $urandom_range(0, 255) & 32'hFC;
            step();
        end
        idle();
        for (int i = 0; i < 5; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_predict_unit.md
Name: fetch_predict_unit

Overview:
Parametrised instruction-fetch front end for the 5-stage RV32I pipeline. It owns the PC, drives the instruction ROM and contains the IF/ID register. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for next-PC prediction, plus a stall (hold) path. Downstream EX/MEM logic resolves branches and jumps, then returns a redirect and a predictor update.

Parameters:
XLEN, 32, datapath/PC width
IMEM_AW, 6, instruction ROM word-address width
BTB_ENTRIES, 16, BTB depth; power of 2, >=2
TAG_W, 8, BTB tag width taken from pc[IDX+2+TAG_W-1 : IDX+2], where IDX = log2(BTB_ENTRIES)
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold PC and IF/ID (load-use hazard)
redirect_i  in  1  mispredict/jump resolved downstream; flush and refetch
redirect_pc_i  in  XLEN  correct next PC
upd_valid_i  in  1  resolved control-flow instruction, updates the BTB
upd_pc_i  in  XLEN  PC of the resolved instruction
upd_taken_i  in  1  actual outcome
upd_target_i  in  XLEN  actual taken target
imem_addr_o  out  IMEM_AW  ROM word address = pc[IMEM_AW+1:2]
imem_rdata_i  in  32  ROM data, combinational, same cycle
pc_o  out  XLEN  current IF-stage PC
if_id_valid_o  out  1  IF/ID holds a real instruction
if_id_pc_o  out  XLEN  PC of the IF/ID instruction
if_id_instr_o  out  32  IF/ID instruction
if_id_pred_taken_o  out  1  prediction made for that instruction
if_id_pred_target_o  out  XLEN  predicted target (valid when pred_taken=1)

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC.
  - if_id_valid=0, if_id_pc=0, if_id_instr=32'h0000_0013 (NOP), pred_taken=0, pred_target=0.
  - All BTB valid bits=0; all counters=2'b01 (weakly not-taken).
  - Reset overrides every other input, including an in-flight redirect or update.
- Lookup (combinational on pc):
  - idx=pc[IDX+1:2]; hit = valid[idx] & tag[idx]==pc tag field.
  - pred_taken = hit & ctr[idx][1]; pred_target = tgt[idx].
- Next-PC priority, registered each cycle:
  - redirect_i: pc <= {redirect_pc_i[XLEN-1:2],2'b00}.
  - else stall_i: pc holds.
  - else pred_taken: pc <= pred_target.
  - else pc <= pc+4, wrapping modulo 2^XLEN.
- IF/ID register priority:
  - redirect_i: bubble (valid=0, instr=NOP, pred_taken=0). Flush beats stall.
  - else stall_i: hold all fields.
  - else load valid=1, pc, imem_rdata_i, pred_taken, pred_target.
- Redirect and stall asserted together: redirect wins; the stall is ignored that cycle.
- Latency: an instruction appears on the if_id_* outputs 1 cycle after its PC is on pc_o. The first valid instruction after reset appears 1 cycle after rst deasserts.
- BTB update (registered), on upd_valid_i, with uidx/utag from upd_pc_i:
  - Hit: counter +1 if taken, -1 if not, saturating at 2'b11 and 2'b00. On taken, tgt <= upd_target_i.
  - Miss and taken: allocate/replace: valid=1, tag=utag, tgt=upd_target_i, ctr=2'b10.
  - Miss and not-taken: no change.
- Update and lookup on the same entry in the same cycle: lookup sees pre-update contents; the new state is visible next cycle.
- Updates are applied regardless of stall_i and redirect_i.
- imem_addr_o wraps naturally when pc exceeds the ROM range; no error flag.

Test Plan:
- Reset then free-run with no updates -> pc_o 0,4,8,12; if_id_valid goes 1 one cycle after rst drops; if_id_pc trails pc_o by 1 cycle; pred_taken stays 0.
- Update pc=0x10, taken, target 0x40 (miss) -> entry allocated with ctr=10. Next fetch of 0x10 -> pred_taken=1 and next pc_o=0x40.
- Two not-taken updates at 0x10 -> ctr 10->01->00; fetch of 0x10 predicts not-taken (pc 0x14). Third not-taken update -> ctr stays 00 (saturation). Four taken updates -> ctr reaches 11 and stays 11.
- stall_i held 3 cycles at pc=0x08 -> pc_o and all if_id_* outputs frozen; on release, sequence resumes at 0x0C.
- redirect_i with redirect_pc_i=0x23 while stall_i=1 -> next pc_o=0x20; IF/ID becomes valid=0, instr=0x00000013.
- rst asserted mid-run together with redirect_i and upd_valid_i -> pc_o=RESET_PC, all BTB entries invalid (fetch of 0x10 no longer predicts taken), if_id_valid=0.
